// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : issue_scoreboard
// Description : In-order issue scoreboard. Tracks outstanding register writes
//               (per-register countdown) and writeback-port reservations, and
//               stalls the RF/FWD stage on RAW/WAW hazards or writeback
//               collisions. Also counts stalled cycles (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scoreboard #(
    parameter int LAT0 = 2,
    parameter int LAT1 = 4,
    parameter int LAT2 = 4,
    parameter int LAT3 = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_unit,
    input  logic [6:0]  in_rt_addr,
    input  logic [6:0]  in_ra_addr,
    input  logic [6:0]  in_rb_addr,
    input  logic [6:0]  in_rc_addr,
    input  logic        in_use_ra,
    input  logic        in_use_rb,
    input  logic        in_use_rc,
    input  logic        in_reg_write,
    output logic [3:0]  issue_en,
    output logic        stall_raw,
    output logic        stall_wb,
    output logic [15:0] stall_count
);

    // Latencies are 1..7, so three bits hold each one exactly.
    localparam logic [2:0] c_LAT0 = LAT0[2:0];
    localparam logic [2:0] c_LAT1 = LAT1[2:0];
    localparam logic [2:0] c_LAT2 = LAT2[2:0];
    localparam logic [2:0] c_LAT3 = LAT3[2:0];

    logic [2:0]  r_pend [128];   // cycles until each register's write lands
    logic [6:0]  r_wb;           // bit k: writeback k cycles from now
    logic [15:0] r_stall_count;

    logic [2:0]  w_lat;
    logic [2:0]  w_lat_m1;
    logic [7:0]  w_wb_ext;
    logic        w_src_hz;
    logic        w_waw_hz;
    logic        w_issue;
    logic        w_load;

    // Select the writeback latency of the targeted unit.
    always_comb begin
        w_lat = c_LAT0;
        case (in_unit)
            2'd0:    w_lat = c_LAT0;
            2'd1:    w_lat = c_LAT1;
            2'd2:    w_lat = c_LAT2;
            default: w_lat = c_LAT3;
        endcase
    end

    assign w_lat_m1 = w_lat - 3'd1;

    // A source equal to the own destination is just an ordinary read here.
    assign w_src_hz = (in_use_ra && (r_pend[in_ra_addr] != 3'd0))
                   || (in_use_rb && (r_pend[in_rb_addr] != 3'd0))
                   || (in_use_rc && (r_pend[in_rc_addr] != 3'd0));
    assign w_waw_hz = in_reg_write && (r_pend[in_rt_addr] != 3'd0);

    // Extend with a zero on top so a 7-cycle latency never collides.
    assign w_wb_ext = {1'b0, r_wb};

    assign stall_raw   = in_valid && (w_src_hz || w_waw_hz);
    assign stall_wb    = in_valid && in_reg_write && w_wb_ext[w_lat];
    assign in_ready    = !stall_raw && !stall_wb;
    assign w_issue     = in_valid && in_ready;
    assign w_load      = w_issue && in_reg_write;
    assign issue_en    = w_issue ? (4'b0001 << in_unit) : 4'b0000;
    assign stall_count = r_stall_count;

    // Count down outstanding writes; an issuing writer reloads its entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) begin
                r_pend[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 128; i++) begin
                if (r_pend[i] != 3'd0) begin
                    r_pend[i] <= r_pend[i] - 3'd1;
                end
            end
            if (w_load) begin
                r_pend[in_rt_addr] <= w_lat_m1;
            end
        end
    end

    // Advance writeback reservations one cycle; reserve the new writer's slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb <= 7'd0;
        end else if (w_load) begin
            r_wb <= {1'b0, r_wb[6:1]} | (7'd1 << w_lat_m1);
        end else begin
            r_wb <= {1'b0, r_wb[6:1]};
        end
    end

    // Saturating count of cycles where a valid instruction was held back.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 16'd0;
        end else if (in_valid && !in_ready && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_scoreboard
// Description : Directed self-checking bench for issue_scoreboard. Expected
//               handshake outputs are queued when a step is driven and
//               compared when the step's outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_unit;
    logic [6:0]  in_rt_addr;
    logic [6:0]  in_ra_addr;
    logic [6:0]  in_rb_addr;
    logic [6:0]  in_rc_addr;
    logic        in_use_ra;
    logic        in_use_rb;
    logic        in_use_rc;
    logic        in_reg_write;
    logic [3:0]  issue_en;
    logic        stall_raw;
    logic        stall_wb;
    logic [15:0] stall_count;

    issue_scoreboard #(
        .LAT0(2), .LAT1(4), .LAT2(4), .LAT3(7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_unit      (in_unit),
        .in_rt_addr   (in_rt_addr),
        .in_ra_addr   (in_ra_addr),
        .in_rb_addr   (in_rb_addr),
        .in_rc_addr   (in_rc_addr),
        .in_use_ra    (in_use_ra),
        .in_use_rb    (in_use_rb),
        .in_use_rc    (in_use_rc),
        .in_reg_write (in_reg_write),
        .issue_en     (issue_en),
        .stall_raw    (stall_raw),
        .stall_wb     (stall_wb),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {in_ready, issue_en, stall_raw, stall_wb}
    typedef struct packed {
        logic       rdy;
        logic [3:0] en;
        logic       raw;
        logic       wb;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];
    int    vectors;
    int    miscompares;

    task automatic drive(input logic v, input logic [1:0] u, input logic [6:0] rt,
                         input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                         input logic ua, input logic ub, input logic uc, input logic wr);
        in_valid     = v;
        in_unit      = u;
        in_rt_addr   = rt;
        in_ra_addr   = ra;
        in_rb_addr   = rb;
        in_rc_addr   = rc;
        in_use_ra    = ua;
        in_use_rb    = ub;
        in_use_rc    = uc;
        in_reg_write = wr;
    endtask

    task automatic idle_in();
        drive(1'b0, 2'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string tag, input logic rdy, input logic [3:0] en,
                              input logic raw, input logic wb);
        exp_t e;
        e.rdy = rdy;
        e.en  = en;
        e.raw = raw;
        e.wb  = wb;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Sample mid-cycle, check all queued expectations, then cross the edge.
    task automatic step();
        exp_t  e;
        exp_t  o;
        string t;
        @(negedge clk);
        o = {in_ready, issue_en, stall_raw, stall_wb};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            vectors++;
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s observed rdy/en/raw/wb=%b/%b/%b/%b expected=%b/%b/%b/%b",
                       t, o.rdy, o.en, o.raw, o.wb, e.rdy, e.en, e.raw, e.wb);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_count(input string tag, input logic [15:0] exp_cnt);
        vectors++;
        assert (stall_count === exp_cnt) else begin
            miscompares++;
            $error("FAIL %s observed stall_count=%0d expected=%0d", tag, stall_count, exp_cnt);
        end
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        do_reset();

        // Reset state: idle, ready, nothing counted
        chk_count("reset_count", 16'd0);
        expect_out("reset_idle", 1'b1, 4'b0000, 1'b0, 1'b0);
        step();

        // RAW: unit1 writes r5, dependent stalls three cycles
        do_reset();
        drive(1'b1, 2'd1, 7'd5, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("raw_producer", 1'b1, 4'b0010, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'd1, 7'd20, 7'd5, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            expect_out("raw_stall", 1'b0, 4'b0000, 1'b1, 1'b0);
            step();
        end
        expect_out("raw_issue", 1'b1, 4'b0010, 1'b0, 1'b0);
        step();
        chk_count("raw_count", 16'd3);

        // Writeback collision: unit3 at 0, unit1 at 3 collides, issues at 4
        do_reset();
        drive(1'b1, 2'd3, 7'd9, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("wb_producer", 1'b1, 4'b1000, 1'b0, 1'b0);
        step();
        idle_in();
        expect_out("wb_idle1", 1'b1, 4'b0000, 1'b0, 1'b0);
        step();
        expect_out("wb_idle2", 1'b1, 4'b0000, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'd1, 7'd10, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("wb_collide", 1'b0, 4'b0000, 1'b0, 1'b1);
        step();
        expect_out("wb_issue", 1'b1, 4'b0010, 1'b0, 1'b0);
        step();
        chk_count("wb_count", 16'd1);

        // WAW: unit0 writes r3, unit1 rewrite of r3 waits one cycle
        do_reset();
        drive(1'b1, 2'd0, 7'd3, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("waw_producer", 1'b1, 4'b0001, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'd1, 7'd3, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("waw_stall", 1'b0, 4'b0000, 1'b1, 1'b0);
        step();
        expect_out("waw_issue", 1'b1, 4'b0010, 1'b0, 1'b0);
        step();
        chk_count("waw_count", 16'd1);

        // Non-writing instructions on every unit leave no hazards behind
        do_reset();
        for (int u = 0; u < 4; u++) begin
            drive(1'b1, 2'(u), 7'd11, 7'd11, 7'd11, 7'd11, 1'b1, 1'b1, 1'b1, 1'b0);
            expect_out("nowr_b2b", 1'b1, 4'(1 << u), 1'b0, 1'b0);
            step();
        end
        // Reads own destination: not a hazard
        drive(1'b1, 2'd3, 7'd11, 7'd11, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("self_read", 1'b1, 4'b1000, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'd2, 7'd12, 7'd0, 7'd0, 7'd11, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_out("rc_hazard", 1'b0, 4'b0000, 1'b1, 1'b0);
        step();
        chk_count("nowr_count", 16'd1);

        // Reset mid-flight clears pending writes and discards reset-cycle issue
        do_reset();
        drive(1'b1, 2'd3, 7'd7, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("rst_producer", 1'b1, 4'b1000, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'd0, 7'd30, 7'd7, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("rst_prestall", 1'b0, 4'b0000, 1'b1, 1'b0);
        step();
        reset = 1'b1;
        drive(1'b1, 2'd3, 7'd50, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 2'd0, 7'd31, 7'd7, 7'd50, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_out("rst_after", 1'b1, 4'b0001, 1'b0, 1'b0);
        chk_count("rst_count", 16'd0);
        step();

        // Sustained valid reading its own pending destination: 6 of 7 stall
        do_reset();
        drive(1'b1, 2'd3, 7'd100, 7'd100, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (7 * 10922) @(posedge clk);
        #1;
        chk_count("sat_before", 16'd65532);
        repeat (14) @(posedge clk);
        #1;
        chk_count("sat_hold", 16'hFFFF);
        repeat (70) @(posedge clk);
        #1;
        chk_count("sat_hold2", 16'hFFFF);

        idle_in();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
